// File: rtl/ifetch_stage.sv
// ---------------------------------------------------------------------------
// ifetch_stage
//
// Instruction fetch front end. It holds the fetch PC, issues one instruction
// memory read per cycle while buffer space is available, and queues the
// returned words with their addresses in a 2-entry FIFO. Decode drains the
// FIFO through a valid/ready handshake. A redirect from execute reloads the
// PC, empties the FIFO and drops any read still in flight.
//
// Parameters
//   RESET_PC        first fetch address after reset
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous reset, active-low
//   redirect_valid  redirect request from execute
//   redirect_pc     redirect target (bits [1:0] ignored)
//   imem_req        instruction memory read strobe
//   imem_addr       read address (always word aligned)
//   imem_rdata      read data, valid the cycle after imem_req
//   inst_valid      instruction available to decode
//   inst_ready      decode accepts the instruction
//   inst            instruction word at the FIFO head
//   inst_pc         address of inst
// ---------------------------------------------------------------------------
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  // Next sequential fetch address; plain 32-bit add so FFFF_FFFC wraps to 0.
  function automatic logic [DATA_W-1:0] next_pc(input logic [DATA_W-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [DATA_W-1:0] align_pc(input logic [DATA_W-1:0] pc);
    return {pc[DATA_W-1:2], 2'b00};
  endfunction

  // Entries held plus the outstanding read, less what decode takes this cycle.
  function automatic logic [2:0] occupancy(input logic [1:0] cnt,
                                           input logic       in_flight,
                                           input logic       take);
    return {1'b0, cnt} + {2'b00, in_flight} - {2'b00, take};
  endfunction

  // Fetch PC (stage p0: address presented to memory)
  logic [DATA_W-1:0] pc_p0;

  // Outstanding read (stage p1: response arrives this cycle)
  logic              vld_p1;
  logic [DATA_W-1:0] tag_p1;

  // Instruction buffer
  logic [DATA_W-1:0] buf_inst [DEPTH];
  logic [DATA_W-1:0] buf_pc   [DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic running;
  logic pop;
  logic push;
  logic issue;

  // A redirect cycle is dead: nothing issued, delivered or captured.
  assign running    = rst && !redirect_valid;

  assign inst_valid = running && (count != 2'd0);
  assign pop        = inst_valid && inst_ready;

  // The response of the previous cycle's read lands now unless this cycle
  // flushes the pipeline, which is how in-flight reads get discarded.
  assign push       = running && vld_p1;

  // Only fetch when the word is guaranteed a FIFO slot; this is what keeps
  // the buffer from ever overflowing without a memory-side stall.
  assign issue      = running && (occupancy(count, vld_p1, pop) < 3'd2);

  assign imem_req   = issue;
  assign imem_addr  = pc_p0;
  assign inst       = buf_inst[rd_ptr];
  assign inst_pc    = buf_pc[rd_ptr];

  // Control state
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_p0  <= RESET_PC;
      vld_p1 <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (redirect_valid) begin
      pc_p0  <= align_pc(redirect_pc);
      vld_p1 <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (issue) begin
        pc_p0 <= next_pc(pc_p0);
      end
      vld_p1 <= issue;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Datapath: tag capture and FIFO storage carry no reset; validity is
  // tracked entirely by the control state above.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_p1 <= pc_p0;
    end
    if (push) begin
      buf_inst[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= tag_p1;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  ifetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  // Memory: word is address ^ KEY one cycle after a read, noise otherwise.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ KEY;
    else          imem_rdata <= $urandom();
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: the instruction stream is the consecutive word addresses
  // starting at the last reset/redirect target.
  logic [31:0] sb_q[$];
  logic [31:0] sb_next;

  task automatic sb_restart(input logic [31:0] base);
    sb_q.delete();
    sb_next = base;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(sb_next);
      sb_next = sb_next + 32'd4;
    end
  endtask

  // Stimulus: drive one cycle's inputs and tell the model about flushes.
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    if (!r)      sb_restart(RESET_PC);
    else if (rv) sb_restart({rpc[31:2], 2'b00});
  endtask

  // Monitor: occupancy/address model plus in-order delivery check.
  int          occ = 0;
  int          stall = 0;
  logic        req_prev = 1'b0;
  logic [31:0] addr_exp = RESET_PC;
  logic        flush_m, pop_m, push_m;
  logic [31:0] exp_pc;

  always @(negedge clk) begin
    flush_m = !rst || redirect_valid;
    pop_m   = inst_valid && inst_ready;
    chk("inst_valid", 32'(inst_valid), 32'(!flush_m && occ > 0));
    chk("imem_req", 32'(imem_req),
        32'(!flush_m && ((occ + int'(req_prev) - int'(pop_m)) < 2)));
    if (imem_req) chk("imem_addr", imem_addr, addr_exp);
    if (pop_m) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 32'(0), 32'(1));
      end else begin
        exp_pc = sb_q.pop_front();
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst", inst, exp_pc ^ KEY);
        sb_q.push_back(sb_next);
        sb_next = sb_next + 32'd4;
      end
    end
    push_m = req_prev && !flush_m;
    if (flush_m) occ = 0;
    else         occ = occ + int'(push_m) - int'(pop_m);
    chk("no_overflow", 32'(occ <= 2), 32'(1));
    req_prev = imem_req;
    if (!rst)                addr_exp = RESET_PC;
    else if (redirect_valid) addr_exp = {redirect_pc[31:2], 2'b00};
    else if (imem_req)       addr_exp = addr_exp + 32'd4;
    if (rst && !redirect_valid && inst_ready && !inst_valid) stall++;
    else stall = 0;
    chk("stall_bound", 32'(stall > 2), 32'(0));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, rv, rdy;
    logic [31:0] rpc;
    sb_restart(RESET_PC);

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("reset_req", 32'(imem_req), 32'(0));
    chk("reset_valid", 32'(inst_valid), 32'(0));

    // Release: first valid two cycles later, then one per cycle
    step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'(1));
    chk("first_addr", imem_addr, RESET_PC);
    chk("lat_c0_valid", 32'(inst_valid), 32'(0));
    step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("lat_c1_valid", 32'(inst_valid), 32'(0));
    step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("lat_c2_valid", 32'(inst_valid), 32'(1));
    chk("lat_c2_pc", inst_pc, RESET_PC);
    chk("lat_c2_inst", inst, RESET_PC ^ KEY);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("stream_valid", 32'(inst_valid), 32'(1));
    end

    // Back-pressure: two entries buffered, fetch stops at PC 8
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("full_req", 32'(imem_req), 32'(0));
    chk("full_pc", imem_addr, 32'h0000_0008);
    chk("full_head", inst_pc, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect with a full buffer
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    @(negedge clk);
    chk("redir_valid", 32'(inst_valid), 32'(0));
    step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("redir_req", 32'(imem_req), 32'(1));
    chk("redir_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Back-to-back redirects: last wins
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("b2b_addr", imem_addr, 32'h0000_0300);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Address wrap
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // One-cycle reset with an entry buffered and a read in flight
    step(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("mid_rst_valid", 32'(inst_valid), 32'(0));
    chk("mid_rst_req", 32'(imem_req), 32'(0));
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("mid_rst_stale", 32'(inst_valid), 32'(0));
    step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("mid_rst_first_pc", inst_pc, RESET_PC);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      rv  = r && ($urandom_range(0, 31) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
      rdy = ($urandom_range(0, 3) != 0);
      step(r, rv, rpc, rdy);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
